// File: rtl/rmap_window_authenticator_pkg.sv
// Shared types and status codes for the multi-window RMAP
// authorisation unit.
package rmap_auth_pkg;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_CMD    = 8'h02;
  localparam logic [7:0] ST_KEY    = 8'h03;
  localparam logic [7:0] ST_ACCESS = 8'h0A;
  localparam logic [7:0] ST_RMWLEN = 8'h0B;
  localparam logic [7:0] ST_LADDR  = 8'h0C;

  localparam int CMD_WRITE  = 3;
  localparam int CMD_VERIFY = 2;
  localparam int CMD_REPLY  = 1;
  localparam int CMD_INC    = 0;

  localparam logic [3:0] CMD_RMW = 4'b0111;

  typedef struct packed {
    logic rmw;
    logic write;
    logic read;
  } perm_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MATCH,
    S_DECIDE,
    S_ACK,
    S_WAIT_RELEASE
  } auth_state_e;

  function automatic logic cmd_valid(
    input logic [3:0] cmd
  );
    return !(cmd inside {4'b0000, 4'b0001,
                         4'b0100, 4'b0101,
                         4'b0110});
  endfunction

endpackage

// File: rtl/rmap_window_authenticator_if.sv
// Authorisation handshake between RMAPTargetIP (master)
// and the window authenticator (slave).
interface rmap_auth_if;

  logic [7:0]  rmapLogicalAddress;
  logic [3:0]  rmapCommand;
  logic [7:0]  rmapKey;
  logic [7:0]  rmapExtendedAddress;
  logic [31:0] rmapAddress;
  logic [23:0] rmapDataLength;
  logic        requestAuthorization;

  logic        authorizeAck;
  logic        rejectAck;
  logic [7:0]  replyStatus;
  logic [3:0]  matchedWindow;
  logic        matchValid;
  logic        addrInvalid;
  logic        keyInvalid;
  logic        dataLengthInvalid;

  modport master (
    output rmapLogicalAddress, rmapCommand,
    output rmapKey, rmapExtendedAddress,
    output rmapAddress, rmapDataLength,
    output requestAuthorization,
    input  authorizeAck, rejectAck,
    input  replyStatus, matchedWindow,
    input  matchValid, addrInvalid,
    input  keyInvalid, dataLengthInvalid
  );

  modport slave (
    input  rmapLogicalAddress, rmapCommand,
    input  rmapKey, rmapExtendedAddress,
    input  rmapAddress, rmapDataLength,
    input  requestAuthorization,
    output authorizeAck, rejectAck,
    output replyStatus, matchedWindow,
    output matchValid, addrInvalid,
    output keyInvalid, dataLengthInvalid
  );

endinterface

// File: rtl/rmap_window_authenticator_match.sv
// Single-window check: address hit, key, permission
// and max-length, all combinational.
module rmap_window_match
  import rmap_auth_pkg::*;
(
  input  logic        en_i,
  input  logic [7:0]  ext_i,
  input  logic [31:0] base_i,
  input  logic [31:0] limit_i,
  input  logic [7:0]  key_i,
  input  perm_t       perm_i,
  input  logic [23:0] maxlen_i,
  input  logic [7:0]  req_ext_i,
  input  logic [31:0] req_addr_i,
  input  logic [32:0] req_end_i,
  input  logic [23:0] req_len_i,
  input  logic [7:0]  req_key_i,
  input  logic [3:0]  req_cmd_i,
  output logic        hit_o,
  output logic        key_ok_o,
  output logic        perm_ok_o,
  output logic        len_ok_o
);

  logic in_lo;
  logic in_hi;

  assign in_lo = req_addr_i >= base_i;

  // Zero-length access must still start inside the window.
  assign in_hi = (req_len_i == '0)
               ? (req_addr_i < limit_i)
               : (req_end_i <= {1'b0, limit_i});

  assign hit_o = en_i
              && (req_ext_i == ext_i)
              && in_lo && in_hi;

  assign key_ok_o = req_key_i == key_i;
  assign len_ok_o = req_len_i <= maxlen_i;

  always_comb begin
    perm_ok_o = perm_i.read;
    unique case (1'b1)
      req_cmd_i[CMD_WRITE]:    perm_ok_o = perm_i.write;
      (req_cmd_i == CMD_RMW):  perm_ok_o = perm_i.rmw;
      default: ;
    endcase
  end

endmodule

// File: rtl/rmap_window_authenticator.sv
// Multi-window RMAP authorisation: fixed 4-cycle decision
// with held status and saturating accept/reject counters.
module rmap_window_authenticator
  import rmap_auth_pkg::*;
#(
  parameter int NUM_WINDOWS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] logicalAddress,
  input  logic [NUM_WINDOWS-1:0] winEnable,
  input  logic [NUM_WINDOWS-1:0][7:0] winExtAddr,
  input  logic [NUM_WINDOWS-1:0][31:0] winBase,
  input  logic [NUM_WINDOWS-1:0][31:0] winLimit,
  input  logic [NUM_WINDOWS-1:0][7:0] winKey,
  input  perm_t [NUM_WINDOWS-1:0] winPerm,
  input  logic [NUM_WINDOWS-1:0][23:0] winMaxLen,
  input  logic countClear,
  output logic [CNT_WIDTH-1:0] acceptCount,
  output logic [CNT_WIDTH-1:0] rejectCount,
  rmap_auth_if.slave bus
);

  auth_state_e state_q;

  logic [7:0]  la_q;
  logic [3:0]  cmd_q;
  logic [7:0]  key_q;
  logic [7:0]  ext_q;
  logic [31:0] addr_q;
  logic [23:0] len_q;
  logic [32:0] end_q;
  logic        la_ok_q;

  logic [NUM_WINDOWS-1:0] hit_d, hit_q;
  logic [NUM_WINDOWS-1:0] kok_d, kok_q;
  logic [NUM_WINDOWS-1:0] pok_d, pok_q;
  logic [NUM_WINDOWS-1:0] lok_d, lok_q;

  logic       auth_q, rej_q;
  logic [7:0] status_q;
  logic [3:0] win_q;
  logic       mv_q, ai_q, ki_q, dli_q;

  logic [CNT_WIDTH-1:0] acc_q, rcnt_q;

  for (genvar g = 0; g < NUM_WINDOWS; g++) begin : g_win
    rmap_window_match u_match (
      .en_i       (winEnable[g]),
      .ext_i      (winExtAddr[g]),
      .base_i     (winBase[g]),
      .limit_i    (winLimit[g]),
      .key_i      (winKey[g]),
      .perm_i     (winPerm[g]),
      .maxlen_i   (winMaxLen[g]),
      .req_ext_i  (ext_q),
      .req_addr_i (addr_q),
      .req_end_i  (end_q),
      .req_len_i  (len_q),
      .req_key_i  (key_q),
      .req_cmd_i  (cmd_q),
      .hit_o      (hit_d[g]),
      .key_ok_o   (kok_d[g]),
      .perm_ok_o  (pok_d[g]),
      .len_ok_o   (lok_d[g])
    );
  end

  logic [3:0] sel_d;
  logic       kok_sel, pok_sel, lok_sel;

  // Lowest hit index wins; no fallthrough to other windows.
  always_comb begin
    sel_d   = '0;
    kok_sel = 1'b0;
    pok_sel = 1'b0;
    lok_sel = 1'b0;
    for (int i = NUM_WINDOWS - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        sel_d   = 4'(i);
        kok_sel = kok_q[i];
        pok_sel = pok_q[i];
        lok_sel = lok_q[i];
      end
    end
  end

  logic [7:0] status_d;
  logic       ai_d, ki_d, dli_d;
  logic       rmw_len_ok;

  assign rmw_len_ok = len_q inside {24'd2, 24'd4,
                                    24'd6, 24'd8};

  always_comb begin
    status_d = ST_OK;
    ai_d     = 1'b0;
    ki_d     = 1'b0;
    dli_d    = 1'b0;
    if (!la_ok_q) begin
      status_d = ST_LADDR;
    end else if (!cmd_valid(cmd_q)) begin
      status_d = ST_CMD;
    end else if (hit_q == '0) begin
      status_d = ST_ACCESS;
      ai_d     = 1'b1;
    end else if (!kok_sel) begin
      status_d = ST_KEY;
      ki_d     = 1'b1;
    end else if (!pok_sel) begin
      status_d = ST_ACCESS;
    end else if (cmd_q == CMD_RMW && !rmw_len_ok) begin
      status_d = ST_RMWLEN;
      dli_d    = 1'b1;
    end else if (!lok_sel) begin
      status_d = ST_ACCESS;
      dli_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      la_q     <= '0;
      cmd_q    <= '0;
      key_q    <= '0;
      ext_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      end_q    <= '0;
      la_ok_q  <= 1'b0;
      hit_q    <= '0;
      kok_q    <= '0;
      pok_q    <= '0;
      lok_q    <= '0;
      auth_q   <= 1'b0;
      rej_q    <= 1'b0;
      status_q <= '0;
      win_q    <= '0;
      mv_q     <= 1'b0;
      ai_q     <= 1'b0;
      ki_q     <= 1'b0;
      dli_q    <= 1'b0;
    end else begin
      auth_q <= 1'b0;
      rej_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.requestAuthorization) begin
            la_q    <= bus.rmapLogicalAddress;
            cmd_q   <= bus.rmapCommand;
            key_q   <= bus.rmapKey;
            ext_q   <= bus.rmapExtendedAddress;
            addr_q  <= bus.rmapAddress;
            len_q   <= bus.rmapDataLength;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          end_q   <= {1'b0, addr_q} + {9'b0, len_q};
          state_q <= S_MATCH;
        end
        S_MATCH: begin
          la_ok_q <= la_q == logicalAddress;
          hit_q   <= hit_d;
          kok_q   <= kok_d;
          pok_q   <= pok_d;
          lok_q   <= lok_d;
          state_q <= S_DECIDE;
        end
        S_DECIDE: begin
          status_q <= status_d;
          auth_q   <= status_d == ST_OK;
          rej_q    <= status_d != ST_OK;
          win_q    <= sel_d;
          mv_q     <= |hit_q;
          ai_q     <= ai_d;
          ki_q     <= ki_d;
          dli_q    <= dli_d;
          state_q  <= S_ACK;
        end
        S_ACK: begin
          state_q <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!bus.requestAuthorization) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      rcnt_q <= '0;
    end else if (countClear) begin
      acc_q  <= '0;
      rcnt_q <= '0;
    end else begin
      if (auth_q && !(&acc_q)) acc_q <= acc_q + 1'b1;
      if (rej_q && !(&rcnt_q)) rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign bus.authorizeAck      = auth_q;
  assign bus.rejectAck         = rej_q;
  assign bus.replyStatus       = status_q;
  assign bus.matchedWindow     = win_q;
  assign bus.matchValid        = mv_q;
  assign bus.addrInvalid       = ai_q;
  assign bus.keyInvalid        = ki_q;
  assign bus.dataLengthInvalid = dli_q;
  assign acceptCount           = acc_q;
  assign rejectCount           = rcnt_q;

endmodule

// File: tb/tb_rmap_window_authenticator.sv
// Directed scoreboard bench for the window authenticator.
module tb_rmap_window_authenticator;
  import rmap_auth_pkg::*;

  localparam int NW = 4;

  typedef struct {
    logic       auth;
    logic [7:0] st;
    logic [3:0] win;
    logic       mv;
    logic       ai;
    logic       ki;
    logic       dli;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] logicalAddress;
  logic [NW-1:0] winEnable;
  logic [NW-1:0][7:0] winExtAddr;
  logic [NW-1:0][31:0] winBase;
  logic [NW-1:0][31:0] winLimit;
  logic [NW-1:0][7:0] winKey;
  perm_t [NW-1:0] winPerm;
  logic [NW-1:0][23:0] winMaxLen;
  logic countClear;
  logic [15:0] acceptCount;
  logic [15:0] rejectCount;

  rmap_auth_if bus ();

  rmap_window_authenticator #(
    .NUM_WINDOWS (NW),
    .CNT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .logicalAddress (logicalAddress),
    .winEnable      (winEnable),
    .winExtAddr     (winExtAddr),
    .winBase        (winBase),
    .winLimit       (winLimit),
    .winKey         (winKey),
    .winPerm        (winPerm),
    .winMaxLen      (winMaxLen),
    .countClear     (countClear),
    .acceptCount    (acceptCount),
    .rejectCount    (rejectCount),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int ncmp = 0;
  int nfail = 0;
  int acc_m = 0;
  int rej_m = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(
    input logic a, input logic [7:0] st,
    input logic [3:0] w, input logic mv,
    input logic ai, input logic ki, input logic dli);
    exp_t e;
    e.auth = a; e.st = st; e.win = w; e.mv = mv;
    e.ai = ai; e.ki = ki; e.dli = dli;
    return e;
  endfunction

  task automatic drive(input logic [7:0] la,
                       input logic [3:0] cmd,
                       input logic [7:0] key,
                       input logic [7:0] ext,
                       input logic [31:0] addr,
                       input logic [23:0] len);
    bus.rmapLogicalAddress  = la;
    bus.rmapCommand         = cmd;
    bus.rmapKey             = key;
    bus.rmapExtendedAddress = ext;
    bus.rmapAddress         = addr;
    bus.rmapDataLength      = len;
    bus.requestAuthorization = 1'b1;
  endtask

  task automatic wait_check(input string tag,
                            input bit early_drop);
    int cyc;
    exp_t e;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (early_drop && c == 2)
        bus.requestAuthorization = 1'b0;
      if (bus.authorizeAck || bus.rejectAck) begin
        cyc = c;
        break;
      end
    end
    check({tag, ".latency"}, cyc, 4);
    e = sb.pop_front();
    if (cyc != 0) begin
      check({tag, ".auth"}, bus.authorizeAck, e.auth);
      check({tag, ".rej"}, bus.rejectAck, !e.auth);
      check({tag, ".status"}, bus.replyStatus, e.st);
      check({tag, ".mv"}, bus.matchValid, e.mv);
      if (e.mv)
        check({tag, ".win"}, bus.matchedWindow, e.win);
      check({tag, ".ai"}, bus.addrInvalid, e.ai);
      check({tag, ".ki"}, bus.keyInvalid, e.ki);
      check({tag, ".dli"}, bus.dataLengthInvalid, e.dli);
      if (e.auth) acc_m++;
      else rej_m++;
    end
    @(posedge clk); #1;
    check({tag, ".pulse1"},
          {bus.authorizeAck, bus.rejectAck}, 0);
    check({tag, ".accCnt"}, acceptCount, acc_m);
    check({tag, ".rejCnt"}, rejectCount, rej_m);
    @(negedge clk);
    bus.requestAuthorization = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic req(input string tag,
                     input logic [7:0] la,
                     input logic [3:0] cmd,
                     input logic [7:0] key,
                     input logic [31:0] addr,
                     input logic [23:0] len,
                     input exp_t e);
    @(negedge clk);
    drive(la, cmd, key, 8'h00, addr, len);
    sb.push_back(e);
    wait_check(tag, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    countClear = 1'b0;
    logicalAddress = 8'hFE;
    winEnable = 4'b0001;
    winExtAddr = '0;
    winBase = '0;
    winLimit = '0;
    winKey = '0;
    winPerm = '0;
    winMaxLen = '0;
    winLimit[0] = 32'h800;
    winKey[0] = 8'h20;
    winPerm[0] = 3'b111;
    winMaxLen[0] = 24'h100;
    winBase[1] = 32'h400;
    winLimit[1] = 32'h1000;
    winKey[1] = 8'h20;
    winPerm[1] = 3'b111;
    winMaxLen[1] = 24'h100;
    drive(8'hFE, 4'h0, 8'h0, 8'h0, 32'h0, 24'h0);
    bus.requestAuthorization = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ack",
          {bus.authorizeAck, bus.rejectAck}, 0);
    check("rst.status", bus.replyStatus, 0);
    check("rst.mv", bus.matchValid, 0);
    check("rst.acc", acceptCount, 0);
    rst = 1'b1;
    @(negedge clk);

    req("wr_ok", 8'hFE, 4'hC, 8'h20, 32'h100, 24'd4,
        mk(1, ST_OK, 0, 1, 0, 0, 0));
    req("wr_key", 8'hFE, 4'hC, 8'h21, 32'h100, 24'd4,
        mk(0, ST_KEY, 0, 1, 0, 1, 0));
    req("rd_cross", 8'hFE, 4'h3, 8'h20, 32'h7FC, 24'd8,
        mk(0, ST_ACCESS, 0, 0, 1, 0, 0));
    req("rd_fit", 8'hFE, 4'h3, 8'h20, 32'h7FC, 24'd4,
        mk(1, ST_OK, 0, 1, 0, 0, 0));

    winEnable = 4'b0011;
    winPerm[0] = 3'b001;
    req("overlap", 8'hFE, 4'hC, 8'h20, 32'h400, 24'd4,
        mk(0, ST_ACCESS, 0, 1, 0, 0, 0));
    req("rd_w1", 8'hFE, 4'h2, 8'h20, 32'h900, 24'd4,
        mk(1, ST_OK, 1, 1, 0, 0, 0));
    winEnable = 4'b0001;
    winPerm[0] = 3'b111;

    req("rmw_len3", 8'hFE, 4'h7, 8'h20, 32'h100, 24'd3,
        mk(0, ST_RMWLEN, 0, 1, 0, 0, 1));
    req("rmw_len4", 8'hFE, 4'h7, 8'h20, 32'h100, 24'd4,
        mk(1, ST_OK, 0, 1, 0, 0, 0));
    req("cmd0", 8'hFE, 4'h0, 8'h20, 32'h100, 24'd4,
        mk(0, ST_CMD, 0, 1, 0, 0, 0));
    req("laddr", 8'hFF, 4'h0, 8'h21, 32'h100, 24'd4,
        mk(0, ST_LADDR, 0, 1, 0, 0, 0));
    req("maxlen", 8'hFE, 4'h8, 8'h20, 32'h0, 24'h200,
        mk(0, ST_ACCESS, 0, 1, 0, 0, 1));
    req("len0_in", 8'hFE, 4'h2, 8'h20, 32'h7FF, 24'd0,
        mk(1, ST_OK, 0, 1, 0, 0, 0));
    req("len0_lim", 8'hFE, 4'h2, 8'h20, 32'h800, 24'd0,
        mk(0, ST_ACCESS, 0, 0, 1, 0, 0));

    @(negedge clk);
    drive(8'hFE, 4'hC, 8'h20, 8'h01, 32'h100, 24'd4);
    sb.push_back(mk(0, ST_ACCESS, 0, 0, 1, 0, 0));
    wait_check("ext_miss", 1'b0);

    @(negedge clk);
    drive(8'hFE, 4'hC, 8'h20, 8'h00, 32'h100, 24'd4);
    sb.push_back(mk(1, ST_OK, 0, 1, 0, 0, 0));
    wait_check("early_drop", 1'b1);

    // Abort a decision in MATCH; request stays high.
    @(negedge clk);
    drive(8'hFE, 4'hC, 8'h21, 8'h00, 32'h100, 24'd4);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_m = 0;
    rej_m = 0;
    #1;
    check("mid.status", bus.replyStatus, 0);
    check("mid.mv", bus.matchValid, 0);
    check("mid.acc", acceptCount, 0);
    check("mid.rej", rejectCount, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid.noack",
            {bus.authorizeAck, bus.rejectAck}, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(0, ST_KEY, 0, 1, 0, 1, 0));
    wait_check("post_rst", 1'b0);

    @(negedge clk);
    countClear = 1'b1;
    @(negedge clk);
    countClear = 1'b0;
    acc_m = 0;
    rej_m = 0;
    check("clr.acc", acceptCount, acc_m);
    check("clr.rej", rejectCount, rej_m);
    check("sb.empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
